gshare_predictor: RTL

Parametrised branch direction and target predictor sitting between the Fetcher and the ReorderBuffer. It is the successor of the fixed 512-entry, 2-bit bimodal predictor, and adds the following:
- configurable table depth and counter width;
- an optional global-history (gshare) indexing mode with speculative history and mispredict recovery;
- a full next-PC target output instead of a bare immediate;
- a saturating mispredict counter for performance debug.

Prediction is combinational in the fetch cycle; training and history recovery are registered.

---
 rtl/gshare_predictor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/gshare_predictor.sv
// Branch direction/target predictor: bimodal or gshare-indexed saturating counters,
// speculative global history with mispredict recovery, and a saturating mispredict counter.
module gshare_predictor #(
  parameter int IDX_BITS = 9,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 8,
  parameter bit MODE     = 1'b1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                fetch_valid_from_fetcher,
  input  logic [31:0]         pc_from_fetcher,
  input  logic [31:0]         inst_from_fetcher,
  output logic                jump_predict_flag_to_fetcher,
  output logic [31:0]         target_to_fetcher,
  output logic [GHR_BITS-1:0] ghr_to_fetcher,
  input  logic                enable_from_reorderbuffer,
  input  logic [31:0]         inst_addr_from_reorderbuffer,
  input  logic                jump_result_from_reorderbuffer,
  input  logic [GHR_BITS-1:0] ghr_from_reorderbuffer,
  input  logic                mispredict_from_reorderbuffer,
  output logic [15:0]         mispredict_cnt_out
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [CTR_BITS-1:0] pht [ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [15:0]         mispredict_cnt;

  // History only folds into the index in gshare mode; zero-extended to the index width.
  function automatic logic [IDX_BITS-1:0] table_index(input logic [31:0] pc,
                                                      input logic [GHR_BITS-1:0] hist);
    logic [IDX_BITS-1:0] fold;
    fold = MODE ? IDX_BITS'(hist) : '0;
    return pc[IDX_BITS+1:2] ^ fold;
  endfunction

  logic [6:0]          opcode;
  logic                is_jal;
  logic                is_branch;
  logic [31:0]         imm_j;
  logic [31:0]         imm_b;
  logic [IDX_BITS-1:0] lookup_idx;
  logic                ctr_taken;
  logic                branch_taken;

  assign opcode       = inst_from_fetcher[6:0];
  assign is_jal       = (opcode == OP_JAL);
  assign is_branch    = (opcode == OP_BRANCH);
  assign imm_j        = {{12{inst_from_fetcher[31]}}, inst_from_fetcher[19:12],
                         inst_from_fetcher[20], inst_from_fetcher[30:21], 1'b0};
  assign imm_b        = {{20{inst_from_fetcher[31]}}, inst_from_fetcher[7],
                         inst_from_fetcher[30:25], inst_from_fetcher[11:8], 1'b0};
  assign lookup_idx   = table_index(pc_from_fetcher, ghr);
  assign ctr_taken    = pht[lookup_idx][CTR_BITS-1];
  assign branch_taken = is_branch & ctr_taken;

  assign jump_predict_flag_to_fetcher = is_jal | branch_taken;
  assign target_to_fetcher = is_jal       ? pc_from_fetcher + imm_j :
                             branch_taken ? pc_from_fetcher + imm_b :
                                            pc_from_fetcher + 32'd4;
  assign ghr_to_fetcher     = ghr;
  assign mispredict_cnt_out = mispredict_cnt;

  // Handshake: fetch_valid_from_fetcher means this cycle's prediction is consumed
  // (branches then shift history); rdy_in low at an edge drops every update outright.
  logic                update_en;
  logic                recover;
  logic                spec_shift;
  logic [IDX_BITS-1:0] train_idx;
  logic [CTR_BITS-1:0] train_ctr;
  logic [CTR_BITS-1:0] train_next;
  logic [GHR_BITS:0]   spec_hist;
  logic [GHR_BITS:0]   recover_hist;

  assign update_en    = rdy_in & enable_from_reorderbuffer;
  assign recover      = update_en & mispredict_from_reorderbuffer;
  assign spec_shift   = rdy_in & fetch_valid_from_fetcher & is_branch;
  assign train_idx    = table_index(inst_addr_from_reorderbuffer, ghr_from_reorderbuffer);
  assign train_ctr    = pht[train_idx];
  assign spec_hist    = {ghr, ctr_taken};
  assign recover_hist = {ghr_from_reorderbuffer, jump_result_from_reorderbuffer};

  always_comb begin
    train_next = train_ctr;
    if (jump_result_from_reorderbuffer) begin
      if (train_ctr != CTR_MAX) train_next = train_ctr + 1'b1;
    end else if (train_ctr != CTR_ZERO) begin
      train_next = train_ctr - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_INIT;
    end else if (update_en) begin
      pht[train_idx] <= train_next;
    end
  end

  // Recovery wins over a speculative shift in the same cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ghr <= '0;
    end else if (recover) begin
      ghr <= recover_hist[GHR_BITS-1:0];
    end else if (spec_shift) begin
      ghr <= spec_hist[GHR_BITS-1:0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mispredict_cnt <= '0;
    end else if (recover && mispredict_cnt != 16'hFFFF) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{inst_addr_from_reorderbuffer, spec_hist[GHR_BITS], recover_hist[GHR_BITS]};

endmodule
